sa_ctrl: RTL and testbench

SA_CTRL -- requirements
Module: sa_ctrl

---
 rtl/sa_ctrl_pkg.sv | 23 ++
 rtl/sa_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_sa_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sa_ctrl_pkg.sv
// sa_ctrl_pkg: shared types and constants for the systolic-array controller.
//   input_mux_t     - mode broadcast to every PE (PASSTHROUGH / LOAD / PROCESS)
//   sa_ctrl_state_t - controller FSM states
//   SA_ARRAY_DIM_DEFAULT - default edge length of the square PE array
package sa_ctrl_pkg;

  typedef enum logic [1:0] {
    PASSTHROUGH = 2'd0,
    LOAD        = 2'd1,
    PROCESS     = 2'd2
  } input_mux_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WLOAD  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } sa_ctrl_state_t;

  localparam int SA_ARRAY_DIM_DEFAULT = 4;

endpackage

// File: rtl/sa_ctrl.sv
// sa_ctrl: sequencer for a weight-stationary ARRAY_DIM x ARRAY_DIM systolic array.
// Runs one job per accepted start: weight load (WLOAD), activation stream
// (STREAM), pipeline drain (DRAIN), one-cycle completion (DONE).
//
// Optional feature macro: SA_CTRL_WREUSE_EN. When defined, a weight-valid flag
// is set on the LOAD cycle and a start with reuse_w_i=1 skips WLOAD while the
// flag is set. When undefined, reuse_w_i is ignored and WLOAD always runs.
//
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   start_i        - job request; k_len_i / reuse_w_i sampled with it
//   k_len_i        - number of activation vectors to stream
//   reuse_w_i      - request to reuse the currently loaded weights
//   busy_o         - high whenever the FSM is not IDLE
//   done_o         - one-cycle completion pulse
//   w_feed_en_o / w_row_idx_o - weight feeder enable and row to present
//   a_feed_en_o / a_idx_o     - activation feeder enable and vector index
//   mux_o          - PE mode broadcast
//   add_zero_o     - per-row add-zero control (row 0 only)
//   out_valid_o / out_idx_o   - bottom-row result strobe and index (pre-deskew)
//   state_o        - current FSM state, for observation
//
// Handshake: start_i is a level request that is accepted only on a rising edge
// where the FSM is IDLE; it is ignored in every other state. There is no ready
// output: busy_o low means the next start_i edge will be taken.
module sa_ctrl
  import sa_ctrl_pkg::*;
#(
  parameter int ARRAY_DIM = SA_ARRAY_DIM_DEFAULT,
  parameter int K_W       = 8
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    start_i,
  input  logic [K_W-1:0]                          k_len_i,
  input  logic                                    reuse_w_i,
  output logic                                    busy_o,
  output logic                                    done_o,
  output logic                                    w_feed_en_o,
  output logic [((ARRAY_DIM>1)?$clog2(ARRAY_DIM):1)-1:0] w_row_idx_o,
  output logic                                    a_feed_en_o,
  output logic [K_W-1:0]                          a_idx_o,
  output input_mux_t                              mux_o,
  output logic [ARRAY_DIM-1:0]                    add_zero_o,
  output logic                                    out_valid_o,
  output logic [K_W-1:0]                          out_idx_o,
  output sa_ctrl_state_t                          state_o
);

  localparam int RW = (ARRAY_DIM > 1) ? $clog2(ARRAY_DIM) : 1;
  localparam int CW = K_W + 1;           // one spare bit: k_len of all ones never wraps
  localparam int VW = ARRAY_DIM - 1;     // activation-to-result latency in cycles

  sa_ctrl_state_t state;
  logic [CW-1:0]  cnt;                   // phase counter shared by WLOAD/STREAM/DRAIN
  logic [K_W-1:0] k_len;
  logic [VW-1:0]  vpipe;                 // a_feed_en_o delayed through the array
  logic [VW-1:0]  vpipe_n;
  logic           skip;

`ifdef SA_CTRL_WREUSE_EN
  logic w_valid;
  assign skip = reuse_w_i & w_valid;
`else
  logic unused_reuse;
  assign unused_reuse = reuse_w_i;
  assign skip         = 1'b0;
`endif

  // Only the top row starts its partial sum from zero.
  assign add_zero_o  = ARRAY_DIM'(1);
  assign state_o     = state;

  // A vector entering the left edge reaches the bottom row VW cycles later.
  assign vpipe_n     = (vpipe << 1) | VW'(a_feed_en_o);
  assign out_valid_o = vpipe[VW-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      k_len       <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      w_feed_en_o <= 1'b0;
      w_row_idx_o <= '0;
      a_feed_en_o <= 1'b0;
      a_idx_o     <= '0;
      out_idx_o   <= '0;
      mux_o       <= PASSTHROUGH;
      vpipe       <= '0;
`ifdef SA_CTRL_WREUSE_EN
      w_valid     <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      vpipe  <= vpipe_n;
      // Advance the result index only between back-to-back valid cycles so the
      // last index is held instead of stepping past k_len-1.
      if (out_valid_o && vpipe_n[VW-1]) out_idx_o <= out_idx_o + 1'b1;

      case (state)
        ST_IDLE: begin
          if (start_i) begin
            k_len     <= k_len_i;
            busy_o    <= 1'b1;
            cnt       <= '0;
            a_idx_o   <= '0;
            out_idx_o <= '0;
            if (skip) begin
              if (k_len_i == '0) begin
                state  <= ST_DONE;
                done_o <= 1'b1;
                mux_o  <= PASSTHROUGH;
              end else begin
                state       <= ST_STREAM;
                a_feed_en_o <= 1'b1;
                mux_o       <= PROCESS;
              end
            end else begin
              state       <= ST_WLOAD;
              w_feed_en_o <= 1'b1;
              w_row_idx_o <= RW'(ARRAY_DIM - 1);
              mux_o       <= (ARRAY_DIM == 1) ? LOAD : PASSTHROUGH;
            end
          end
        end

        ST_WLOAD: begin
          if (cnt == CW'(ARRAY_DIM - 1)) begin
            // This is the LOAD cycle: weights are latched into the PEs now.
            w_feed_en_o <= 1'b0;
            cnt         <= '0;
`ifdef SA_CTRL_WREUSE_EN
            w_valid     <= 1'b1;
`endif
            if (k_len == '0) begin
              state  <= ST_DONE;
              done_o <= 1'b1;
              mux_o  <= PASSTHROUGH;
            end else begin
              state       <= ST_STREAM;
              a_feed_en_o <= 1'b1;
              mux_o       <= PROCESS;
            end
          end else begin
            cnt         <= cnt + 1'b1;
            w_row_idx_o <= w_row_idx_o - 1'b1;
            mux_o       <= (cnt == CW'(ARRAY_DIM - 2)) ? LOAD : PASSTHROUGH;
          end
        end

        ST_STREAM: begin
          if (cnt == ({1'b0, k_len} - 1'b1)) begin
            state       <= ST_DRAIN;
            cnt         <= '0;
            a_feed_en_o <= 1'b0;
          end else begin
            cnt     <= cnt + 1'b1;
            a_idx_o <= a_idx_o + 1'b1;
          end
        end

        ST_DRAIN: begin
          if (cnt == CW'(2 * ARRAY_DIM - 2)) begin
            state  <= ST_DONE;
            cnt    <= '0;
            done_o <= 1'b1;
            mux_o  <= PASSTHROUGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DONE: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
          mux_o  <= PASSTHROUGH;
        end

        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
          mux_o  <= PASSTHROUGH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sa_ctrl.sv
// tb_sa_ctrl: directed testbench for sa_ctrl with ARRAY_DIM=4, K_W=8.
// Cycle 0 is the cycle in which start_i is high in IDLE; every later cycle of
// the job is compared against the expected controller timeline.
module tb_sa_ctrl;
  import sa_ctrl_pkg::*;

  localparam int N   = 4;
  localparam int K_W = 8;

  logic           clk_i;
  logic           rst_ni;
  logic           start_i;
  logic [K_W-1:0] k_len_i;
  logic           reuse_w_i;
  logic           busy_o;
  logic           done_o;
  logic           w_feed_en_o;
  logic [1:0]     w_row_idx_o;
  logic           a_feed_en_o;
  logic [K_W-1:0] a_idx_o;
  input_mux_t     mux_o;
  logic [N-1:0]   add_zero_o;
  logic           out_valid_o;
  logic [K_W-1:0] out_idx_o;
  sa_ctrl_state_t state_o;

  int checks   = 0;
  int failures = 0;

  sa_ctrl #(.ARRAY_DIM(N), .K_W(K_W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .k_len_i     (k_len_i),
    .reuse_w_i   (reuse_w_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .w_feed_en_o (w_feed_en_o),
    .w_row_idx_o (w_row_idx_o),
    .a_feed_en_o (a_feed_en_o),
    .a_idx_o     (a_idx_o),
    .mux_o       (mux_o),
    .add_zero_o  (add_zero_o),
    .out_valid_o (out_valid_o),
    .out_idx_o   (out_idx_o),
    .state_o     (state_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},   int'(busy_o),      0);
    check({tag, "_done"},   int'(done_o),      0);
    check({tag, "_wfe"},    int'(w_feed_en_o), 0);
    check({tag, "_afe"},    int'(a_feed_en_o), 0);
    check({tag, "_ovalid"}, int'(out_valid_o), 0);
    check({tag, "_row"},    int'(w_row_idx_o), 0);
    check({tag, "_aidx"},   int'(a_idx_o),     0);
    check({tag, "_oidx"},   int'(out_idx_o),   0);
    check({tag, "_mux"},    int'(mux_o),       int'(PASSTHROUGH));
    check({tag, "_state"},  int'(state_o),     int'(ST_IDLE));
    check({tag, "_addz"},   int'(add_zero_o),  1);
  endtask

  // Drive one job and compare every cycle up to the first IDLE cycle after it.
  // wl: WLOAD expected; pulse_c: extra start pulse cycle (0 = none);
  // abort_c: return early at that cycle (0 = run to completion).
  task automatic run_job(input string tag, input int k, input bit wl, input bit reuse,
                         input int pulse_c, input int abort_c);
    int wn, s0, d0, done_c, v0, ndone;
    bit e_wfe, e_afe, e_val;
    int e_mux;
    wn     = wl ? N : 0;
    s0     = wn + 1;
    d0     = s0 + k;
    done_c = (k == 0) ? d0 : d0 + 2 * N - 1;
    v0     = s0 + N - 1;
    ndone  = 0;
    start_i   = 1'b1;
    k_len_i   = K_W'(k);
    reuse_w_i = reuse;
    for (int c = 1; c <= done_c + 1; c++) begin
      step();
      start_i   = (c == pulse_c);
      reuse_w_i = 1'b0;
      if (c == abort_c) return;
      e_wfe = (c >= 1) && (c <= wn);
      e_afe = (c >= s0) && (c < d0);
      e_val = (c >= v0) && (c < v0 + k);
      if (e_wfe)                      e_mux = (c == wn) ? int'(LOAD) : int'(PASSTHROUGH);
      else if (c >= s0 && c < done_c) e_mux = int'(PROCESS);
      else                            e_mux = int'(PASSTHROUGH);
      if (done_o) ndone++;
      check({tag, "_busy"}, int'(busy_o),      int'(c <= done_c));
      check({tag, "_done"}, int'(done_o),      int'(c == done_c));
      check({tag, "_wfe"},  int'(w_feed_en_o), int'(e_wfe));
      check({tag, "_afe"},  int'(a_feed_en_o), int'(e_afe));
      check({tag, "_oval"}, int'(out_valid_o), int'(e_val));
      check({tag, "_mux"},  int'(mux_o),       e_mux);
      check({tag, "_addz"}, int'(add_zero_o),  1);
      if (e_wfe) check({tag, "_row"},  int'(w_row_idx_o), N - c);
      if (e_afe) check({tag, "_aidx"}, int'(a_idx_o),     c - s0);
      if (e_val) check({tag, "_oidx"}, int'(out_idx_o),   c - v0);
    end
    check({tag, "_ndone"}, ndone, 1);
  endtask

  initial begin
    rst_ni    = 1'b0;
    start_i   = 1'b0;
    k_len_i   = '0;
    reuse_w_i = 1'b0;
    repeat (2) step();
    check_reset_values("rst_init");
    rst_ni = 1'b1;
    step();

    run_job("k3",    3, 1'b1, 1'b0, 0, 0);
    run_job("k0",    0, 1'b1, 1'b0, 0, 0);
    // start pulsed in the second STREAM cycle (cycle 6) must be ignored
    run_job("pulse", 3, 1'b1, 1'b0, N + 2, 0);
    step();
    check("pulse_idle", int'(busy_o), 0);

    // reset during the second STREAM cycle, checked before any clock edge
    run_job("abort", 5, 1'b1, 1'b0, 0, N + 2);
    #2 rst_ni = 1'b0;
    #1 check_reset_values("rst_mid");
    #3 rst_ni = 1'b1;
    // weight-valid flag is cleared by reset, so reuse still loads weights
    run_job("post_rst", 3, 1'b1, 1'b1, 0, 0);

`ifdef SA_CTRL_WREUSE_EN
    run_job("reuse_k2", 2, 1'b0, 1'b1, 0, 0);
    run_job("reuse_k0", 0, 1'b0, 1'b1, 0, 0);
`else
    run_job("noreuse_k2", 2, 1'b1, 1'b1, 0, 0);
`endif

    run_job("k255", 255, 1'b1, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
